mem_store_pack: RTL and testbench

MEM_STORE_PACK -- requirements
Module: mem_store_pack

---
 rtl/mem_store_pack.sv | 133 +++++++++++++
 tb/tb_mem_store_pack.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_store_pack.sv
// mem_store_pack: MEM-stage store packer with a one-entry output register.
// Stores are checked for address/alignment faults and formatted into a
// word-aligned bus write with lane-replicated data and byte enables.
// Timer count registers (offset 8 in each timer window) are read-only.
module mem_store_pack #(
    parameter logic [31:0] DM_END   = 32'h0000_3000,
    parameter logic [31:0] TC0_BASE = 32'h0000_7F00,
    parameter logic [31:0] TC1_BASE = 32'h0000_7F10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  StoreOp,
    input  logic [31:0] Addr,
    input  logic [31:0] WD,
    output logic        ExcAdES,
    output logic        bus_valid,
    input  logic        bus_ready,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_byteen
);

    localparam logic [1:0]  OP_SW     = 2'b00;
    localparam logic [1:0]  OP_SH     = 2'b01;
    localparam logic [1:0]  OP_SB     = 2'b10;
    localparam logic [31:0] TC_WINDOW = 32'd12;
    localparam logic [31:0] TC_COUNT  = 32'd8;

    // Replicate the payload across every lane it may be written to.
    function automatic logic [31:0] pack_wdata(input logic [1:0] op, input logic [31:0] wd);
        logic [31:0] res;
        case (op)
            OP_SW:   res = wd;
            OP_SH:   res = {wd[15:0], wd[15:0]};
            OP_SB:   res = {4{wd[7:0]}};
            default: res = 32'h0000_0000;
        endcase
        return res;
    endfunction

    // Select the byte lanes addressed by the store.
    function automatic logic [3:0] pack_byteen(input logic [1:0] op, input logic [31:0] addr);
        logic [3:0] res;
        case (op)
            OP_SW:   res = 4'b1111;
            OP_SH:   res = addr[1] ? 4'b1100 : 4'b0011;
            OP_SB:   res = 4'b0001 << addr[1:0];
            default: res = 4'b0000;
        endcase
        return res;
    endfunction

    // Any reason the store must raise an address-error exception instead.
    function automatic logic store_fault(input logic [1:0] op, input logic [31:0] addr);
        logic in_dm;
        logic in_tc0;
        logic in_tc1;
        logic bad_align;
        logic bad_timer;
        in_dm  = (addr < DM_END);
        in_tc0 = (addr >= TC0_BASE) && (addr < (TC0_BASE + TC_WINDOW));
        in_tc1 = (addr >= TC1_BASE) && (addr < (TC1_BASE + TC_WINDOW));
        case (op)
            OP_SW:   bad_align = (addr[1:0] != 2'b00);
            OP_SH:   bad_align = addr[0];
            OP_SB:   bad_align = 1'b0;
            default: bad_align = 1'b1;
        endcase
        bad_timer = ((in_tc0 || in_tc1) && (op != OP_SW)) ||
                    (in_tc0 && ((addr - TC0_BASE) == TC_COUNT)) ||
                    (in_tc1 && ((addr - TC1_BASE) == TC_COUNT));
        return bad_align || bad_timer || !(in_dm || in_tc0 || in_tc1);
    endfunction

    logic        valid_r;
    logic        exc_r;
    logic [31:0] addr_r;
    logic [31:0] wdata_r;
    logic [3:0]  byteen_r;

    logic        accept_s;
    logic        fault_s;
    logic        load_s;
    logic        drain_s;

    assign req_ready  = !valid_r || bus_ready;
    assign ExcAdES    = exc_r;
    assign bus_valid  = valid_r;
    assign bus_addr   = addr_r;
    assign bus_wdata  = wdata_r;
    assign bus_byteen = byteen_r;

    // Handshake decode: accept, classify, and decide load versus drain.
    always_comb begin
        accept_s = req_valid && req_ready;
        fault_s  = store_fault(StoreOp, Addr);
        load_s   = 1'b0;
        drain_s  = 1'b0;
        if (accept_s && !fault_s) begin
            load_s = 1'b1;
        end else if (valid_r && bus_ready) begin
            drain_s = 1'b1;
        end else begin
            drain_s = 1'b0;
        end
    end

    // Output register and exception flag, with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_r  <= 1'b0;
            exc_r    <= 1'b0;
            addr_r   <= 32'h0000_0000;
            wdata_r  <= 32'h0000_0000;
            byteen_r <= 4'b0000;
        end else begin
            exc_r <= accept_s && fault_s;
            if (load_s) begin
                valid_r  <= 1'b1;
                addr_r   <= {Addr[31:2], 2'b00};
                wdata_r  <= pack_wdata(StoreOp, WD);
                byteen_r <= pack_byteen(StoreOp, Addr);
            end else if (drain_s) begin
                valid_r <= 1'b0;
            end else begin
                valid_r <= valid_r;
            end
        end
    end

endmodule

// File: tb/tb_mem_store_pack.sv
// tb_mem_store_pack: directed scenarios for the store packer.
module tb_mem_store_pack;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  StoreOp;
    logic [31:0] Addr;
    logic [31:0] WD;
    logic        ExcAdES;
    logic        bus_valid;
    logic        bus_ready;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_byteen;

    int checks;
    int failures;

    mem_store_pack dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .StoreOp    (StoreOp),
        .Addr       (Addr),
        .WD         (WD),
        .ExcAdES    (ExcAdES),
        .bus_valid  (bus_valid),
        .bus_ready  (bus_ready),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_byteen (bus_byteen)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d);
        req_valid = 1'b1;
        StoreOp   = op;
        Addr      = a;
        WD        = d;
    endtask

    task automatic idle();
        req_valid = 1'b0;
        StoreOp   = 2'b00;
        Addr      = 32'h0000_0000;
        WD        = 32'h0000_0000;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus_ready = 1'b1;
        present(2'b00, 32'h0000_0004, 32'hCAFE_F00D);
        step();
        step();
        checks++; if (bus_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b want=0", bus_valid); end
        checks++; if (ExcAdES !== 1'b0) begin failures++; $display("FAIL rst_exc got=%b want=0", ExcAdES); end
        checks++; if (bus_addr !== 32'h0) begin failures++; $display("FAIL rst_addr got=%h want=0", bus_addr); end
        checks++; if (bus_wdata !== 32'h0) begin failures++; $display("FAIL rst_wdata got=%h want=0", bus_wdata); end
        checks++; if (bus_byteen !== 4'b0000) begin failures++; $display("FAIL rst_byteen got=%b want=0000", bus_byteen); end
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b want=1", req_ready); end
        idle();
        reset = 1'b1;
        step();
        checks++; if (bus_valid !== 1'b0) begin failures++; $display("FAIL post_rst_valid got=%b want=0", bus_valid); end
    endtask

    task automatic test_sb();
        bus_ready = 1'b1;
        present(2'b10, 32'h0000_0013, 32'h1234_56AB);
        step();
        idle();
        checks++; if (bus_valid !== 1'b1) begin failures++; $display("FAIL sb_valid got=%b want=1", bus_valid); end
        checks++; if (bus_addr !== 32'h0000_0010) begin failures++; $display("FAIL sb_addr got=%h want=00000010", bus_addr); end
        checks++; if (bus_wdata !== 32'hABAB_ABAB) begin failures++; $display("FAIL sb_wdata got=%h want=abababab", bus_wdata); end
        checks++; if (bus_byteen !== 4'b1000) begin failures++; $display("FAIL sb_byteen got=%b want=1000", bus_byteen); end
        checks++; if (ExcAdES !== 1'b0) begin failures++; $display("FAIL sb_exc got=%b want=0", ExcAdES); end
        step();
        checks++; if (bus_valid !== 1'b0) begin failures++; $display("FAIL sb_drain got=%b want=0", bus_valid); end
    endtask

    task automatic test_sh_misalign();
        bus_ready = 1'b1;
        present(2'b01, 32'h0000_0102, 32'hFFFF_BEEF);
        step();
        checks++; if (bus_addr !== 32'h0000_0100) begin failures++; $display("FAIL sh_addr got=%h want=00000100", bus_addr); end
        checks++; if (bus_wdata !== 32'hBEEF_BEEF) begin failures++; $display("FAIL sh_wdata got=%h want=beefbeef", bus_wdata); end
        checks++; if (bus_byteen !== 4'b1100) begin failures++; $display("FAIL sh_byteen_hi got=%b want=1100", bus_byteen); end
        // Reload while draining: lower halfword.
        present(2'b01, 32'h0000_0200, 32'h0000_1357);
        step();
        checks++; if (bus_valid !== 1'b1) begin failures++; $display("FAIL sh_reload_valid got=%b want=1", bus_valid); end
        checks++; if (bus_wdata !== 32'h1357_1357) begin failures++; $display("FAIL sh_lo_wdata got=%h want=13571357", bus_wdata); end
        checks++; if (bus_byteen !== 4'b0011) begin failures++; $display("FAIL sh_byteen_lo got=%b want=0011", bus_byteen); end
        // Misaligned sw accepted while the pending store drains.
        present(2'b00, 32'h0000_0106, 32'h1111_2222);
        step();
        idle();
        checks++; if (ExcAdES !== 1'b1) begin failures++; $display("FAIL sw_mis_exc got=%b want=1", ExcAdES); end
        checks++; if (bus_valid !== 1'b0) begin failures++; $display("FAIL sw_mis_valid got=%b want=0", bus_valid); end
        step();
        checks++; if (ExcAdES !== 1'b0) begin failures++; $display("FAIL sw_mis_exc_pulse got=%b want=0", ExcAdES); end
        present(2'b01, 32'h0000_0101, 32'h0000_0000);
        step();
        idle();
        checks++; if (ExcAdES !== 1'b1) begin failures++; $display("FAIL sh_odd_exc got=%b want=1", ExcAdES); end
        step();
    endtask

    task automatic test_windows();
        bus_ready = 1'b1;
        present(2'b00, 32'h0000_7F08, 32'h0000_0001);
        step();
        checks++; if (ExcAdES !== 1'b1) begin failures++; $display("FAIL tc0_count_exc got=%b want=1", ExcAdES); end
        checks++; if (bus_valid !== 1'b0) begin failures++; $display("FAIL tc0_count_valid got=%b want=0", bus_valid); end
        present(2'b00, 32'h0000_7F14, 32'h0000_0055);
        step();
        checks++; if (ExcAdES !== 1'b0) begin failures++; $display("FAIL tc1_preset_exc got=%b want=0", ExcAdES); end
        checks++; if (bus_valid !== 1'b1) begin failures++; $display("FAIL tc1_preset_valid got=%b want=1", bus_valid); end
        checks++; if (bus_byteen !== 4'b1111) begin failures++; $display("FAIL tc1_preset_byteen got=%b want=1111", bus_byteen); end
        checks++; if (bus_addr !== 32'h0000_7F14) begin failures++; $display("FAIL tc1_preset_addr got=%h want=00007f14", bus_addr); end
        present(2'b10, 32'h0000_7F00, 32'h0000_0000);
        step();
        checks++; if (ExcAdES !== 1'b1) begin failures++; $display("FAIL tc0_sb_exc got=%b want=1", ExcAdES); end
        checks++; if (bus_valid !== 1'b0) begin failures++; $display("FAIL tc0_sb_valid got=%b want=0", bus_valid); end
        present(2'b00, 32'h0000_3000, 32'h0000_0000);
        step();
        checks++; if (ExcAdES !== 1'b1) begin failures++; $display("FAIL dm_end_exc got=%b want=1", ExcAdES); end
        present(2'b00, 32'h0000_7F0C, 32'h0000_0000);
        step();
        checks++; if (ExcAdES !== 1'b1) begin failures++; $display("FAIL tc0_past_exc got=%b want=1", ExcAdES); end
        present(2'b11, 32'h0000_0000, 32'h0000_0000);
        step();
        checks++; if (ExcAdES !== 1'b1) begin failures++; $display("FAIL reserved_op_exc got=%b want=1", ExcAdES); end
        present(2'b10, 32'h0000_2FFF, 32'h0000_00C3);
        step();
        idle();
        checks++; if (ExcAdES !== 1'b0) begin failures++; $display("FAIL dm_last_exc got=%b want=0", ExcAdES); end
        checks++; if (bus_valid !== 1'b1) begin failures++; $display("FAIL dm_last_valid got=%b want=1", bus_valid); end
        checks++; if (bus_addr !== 32'h0000_2FFC) begin failures++; $display("FAIL dm_last_addr got=%h want=00002ffc", bus_addr); end
        checks++; if (bus_wdata !== 32'hC3C3_C3C3) begin failures++; $display("FAIL dm_last_wdata got=%h want=c3c3c3c3", bus_wdata); end
        step();
    endtask

    task automatic test_stall();
        bus_ready = 1'b0;
        present(2'b00, 32'h0000_0020, 32'hDEAD_BEEF);
        step();
        checks++; if (bus_valid !== 1'b1) begin failures++; $display("FAIL stall_first_valid got=%b want=1", bus_valid); end
        present(2'b00, 32'h0000_0024, 32'h1111_1111);
        for (int i = 0; i < 3; i++) begin
            checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL stall_ready[%0d] got=%b want=0", i, req_ready); end
            step();
            checks++; if (bus_addr !== 32'h0000_0020 || bus_wdata !== 32'hDEAD_BEEF || bus_byteen !== 4'b1111 || bus_valid !== 1'b1) begin
                failures++; $display("FAIL stall_hold[%0d] got=%b/%h/%h/%b want=1/00000020/deadbeef/1111", i, bus_valid, bus_addr, bus_wdata, bus_byteen);
            end
        end
        bus_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL stall_release_ready got=%b want=1", req_ready); end
        step();
        idle();
        checks++; if (bus_valid !== 1'b1 || bus_addr !== 32'h0000_0024 || bus_wdata !== 32'h1111_1111) begin
            failures++; $display("FAIL stall_next got=%b/%h/%h want=1/00000024/11111111", bus_valid, bus_addr, bus_wdata);
        end
        step();
        checks++; if (bus_valid !== 1'b0) begin failures++; $display("FAIL stall_drain got=%b want=0", bus_valid); end
        // bus_ready pulses while empty are ignored.
        step();
        checks++; if (bus_valid !== 1'b0 || bus_addr !== 32'h0000_0024) begin failures++; $display("FAIL idle_ready got=%b/%h want=0/00000024", bus_valid, bus_addr); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a;
        bus_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a = 32'h0000_0040 + 32'(i * 4);
            present(2'b00, a, 32'hA5A5_0000 + 32'(i));
            #1;
            checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready[%0d] got=%b want=1", i, req_ready); end
            step();
            checks++; if (bus_valid !== 1'b1 || bus_addr !== a || bus_wdata !== (32'hA5A5_0000 + 32'(i))) begin
                failures++; $display("FAIL b2b_bus[%0d] got=%b/%h/%h want=1/%h/%h", i, bus_valid, bus_addr, bus_wdata, a, 32'hA5A5_0000 + 32'(i));
            end
        end
        idle();
        step();
        checks++; if (bus_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%b want=0", bus_valid); end
    endtask

    task automatic test_reset_pending();
        bus_ready = 1'b0;
        present(2'b00, 32'h0000_0050, 32'h7777_8888);
        step();
        idle();
        checks++; if (bus_valid !== 1'b1) begin failures++; $display("FAIL rp_pending got=%b want=1", bus_valid); end
        reset = 1'b0;
        step();
        reset = 1'b1;
        checks++; if (bus_valid !== 1'b0 || ExcAdES !== 1'b0 || bus_addr !== 32'h0 || bus_wdata !== 32'h0 || bus_byteen !== 4'b0000) begin
            failures++; $display("FAIL rp_clear got=%b/%b/%h/%h/%b want=0/0/0/0/0", bus_valid, ExcAdES, bus_addr, bus_wdata, bus_byteen);
        end
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rp_ready got=%b want=1", req_ready); end
        step();
        checks++; if (bus_valid !== 1'b0) begin failures++; $display("FAIL rp_no_revive got=%b want=0", bus_valid); end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        clk       = 1'b0;
        reset     = 1'b0;
        bus_ready = 1'b0;
        idle();
        test_reset();
        test_sb();
        test_sh_misalign();
        test_windows();
        test_stall();
        test_back_to_back();
        test_reset_pending();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
